ex_muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit in the EX stage.
//  - Fed from the ID/EX pipeline register outputs.
//  - Holds the pipeline through stall_req while it computes.
//  - Delivers one result per accepted op, with a one-cycle valid_out, to the EX/MEM boundary.
//  - Radix-2 shift-add (multiply) and restoring shift-subtract (divide); no hardware multiplier.

---
 rtl/ex_muldiv_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage.
// Radix-2 shift-add multiply, restoring divide, one bit per cycle.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       rd_in,
  output logic             stall_req,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             neg_q;
  logic [WIDTH-1:0] m;
  logic [2*WIDTH-1:0] p, p_nxt;

  logic             a_sgn, b_sgn, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div0, ovf, special, accept;
  logic [WIDTH-1:0] spec_res, res_calc;

  logic [WIDTH:0]     add_s, sub_s;
  logic [2*WIDTH:0]   sh;
  logic [2*WIDTH-1:0] mul_v;
  logic [WIDTH-1:0]   quo_v, rem_v;

  // Operand decode: signedness, magnitudes and the special cases
  always_comb begin
    a_sgn  = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6)
           & a[WIDTH-1];
    b_sgn  = (op == 3'd1 || op == 3'd4 || op == 3'd6) & b[WIDTH-1];
    a_mag  = a_sgn ? -a : a;
    b_mag  = b_sgn ? -b : b;
    neg_in = (op == 3'd6) ? a_sgn : (a_sgn ^ b_sgn);
    div0   = op[2] & (b == '0);
    ovf    = (op == 3'd4 || op == 3'd6) & (a == MIN) & (b == '1);
    special = div0 | ovf;
    accept = (state == IDLE) & start & ~flush;
    spec_res = '0;
    if (div0)
      spec_res = op[1] ? a : '1;
    else
      spec_res = op[1] ? '0 : MIN;
  end

  // One multiply or divide iteration, and the sign-corrected result
  always_comb begin
    add_s = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : '0)};
    sh    = {p, 1'b0};
    sub_s = sh[2*WIDTH:WIDTH] - {1'b0, m};
    if (op_q[2]) begin
      if (sub_s[WIDTH])
        p_nxt = sh[2*WIDTH-1:0];
      else
        p_nxt = {sub_s[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
    end else begin
      p_nxt = {add_s, p[WIDTH-1:1]};
    end
    mul_v = neg_q ? -p_nxt : p_nxt;
    quo_v = neg_q ? -p_nxt[WIDTH-1:0] : p_nxt[WIDTH-1:0];
    rem_v = neg_q ? -p_nxt[2*WIDTH-1:WIDTH] : p_nxt[2*WIDTH-1:WIDTH];
    res_calc = '0;
    unique case (1'b1)
      (~op_q[2] & (op_q[1:0] == 2'd0)): res_calc = mul_v[WIDTH-1:0];
      (~op_q[2] & (op_q[1:0] != 2'd0)): res_calc = mul_v[2*WIDTH-1:WIDTH];
      (op_q[2] & ~op_q[1]):             res_calc = quo_v;
      (op_q[2] & op_q[1]):              res_calc = rem_v;
      default:                          res_calc = '0;
    endcase
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign stall_req = accept | (state == CALC);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      m         <= '0;
      p         <= '0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      valid_out <= (state_nxt == DONE);
      if (accept) begin
        op_q  <= op;
        rd_q  <= rd_in;
        neg_q <= neg_in;
        m     <= op[2] ? b_mag : a_mag;
        p     <= {{WIDTH{1'b0}}, (op[2] ? a_mag : b_mag)};
        cnt   <= CW'(WIDTH-1);
        if (special) begin
          result <= spec_res;
          rd_out <= rd_in;
        end
      end else if ((state == CALC) && !flush) begin
        p   <= p_nxt;
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          result <= res_calc;
          rd_out <= rd_q;
        end
      end
    end
  end

endmodule
